// File: rtl/sdram_rr_scheduler.sv
// sdram_rr_scheduler: four-port round-robin arbiter for the 4-word-burst SDRAM controller,
// with an urgent override for the display read port and a hung-transaction watchdog.
module sdram_rr_scheduler #(
    parameter int URGENT_CYC  = 64,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [3:0]   i_req,
    input  logic [3:0]   i_we,
    input  logic [95:0]  i_addr,
    input  logic [255:0] i_wdata,
    output logic [3:0]   o_done,
    output logic [63:0]  o_rdata,
    output logic [3:0]   o_grant,
    output logic         o_err,
    input  logic         i_err_clr,
    output logic [1:0]   sdram_req,
    output logic [23:0]  sdram_addr,
    output logic [63:0]  sdram_wdata,
    input  logic [63:0]  sdram_rdata,
    input  logic [1:0]   sdram_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    state, ptr, own, win, idx;
    logic [3:0]    mask, cand;
    logic [6:0]    wait_cnt;
    logic [TW-1:0] tmo;
    logic          found, urgent, go, hit;

    always_comb begin
        cand   = i_req & ~mask;
        urgent = int'(wait_cnt) >= URGENT_CYC;
        win    = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        if (urgent && cand[0]) win = 2'd0;
        go  = (state == IDLE) && en && found;
        hit = |(sdram_req & sdram_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            own         <= 2'd0;
            mask        <= 4'd0;
            wait_cnt    <= 7'd0;
            tmo         <= '0;
            o_done      <= 4'd0;
            o_rdata     <= 64'd0;
            o_grant     <= 4'd0;
            o_err       <= 1'b0;
            sdram_req   <= 2'd0;
            sdram_addr  <= 24'd0;
            sdram_wdata <= 64'd0;
        end else begin
            if (i_err_clr) o_err <= 1'b0;
            if (!i_req[0] || (go && win == 2'd0)) wait_cnt <= 7'd0;
            else if (!o_grant[0] && !(&wait_cnt)) wait_cnt <= wait_cnt + 7'd1;
            if (state == IDLE) begin
                mask <= 4'd0;
                if (go) begin
                    state       <= ISSUE;
                    own         <= win;
                    o_grant     <= 4'b0001 << win;
                    sdram_addr  <= i_addr[24*win +: 24];
                    sdram_wdata <= i_wdata[64*win +: 64];
                    sdram_req   <= i_we[win] ? 2'b10 : 2'b01;
                    tmo         <= '0;
                end
            end else if (state == ISSUE) begin
                if (hit || tmo == TW'(TIMEOUT_CYC)) begin
                    state     <= DONE;
                    sdram_req <= 2'd0;
                    o_done    <= o_grant;
                    ptr       <= own;
                    if (hit && sdram_req[0]) o_rdata <= sdram_rdata;
                    if (!hit) o_err <= 1'b1;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                // one-cycle mask lets the finished requester drop req a cycle late
                state   <= IDLE;
                mask    <= o_grant;
                o_done  <= 4'd0;
                o_grant <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_rr_scheduler.sv
// tb_sdram_rr_scheduler: directed checks of arbitration order, urgency, watchdog, enable,
// reset and stale-request masking; dut_b runs with a short urgency threshold.
module tb_sdram_rr_scheduler;
    logic         clk, rst, en, i_err_clr;
    logic [3:0]   i_req, i_we;
    logic [95:0]  i_addr;
    logic [255:0] i_wdata;
    logic [63:0]  sdram_rdata;
    logic [1:0]   sdram_done;
    logic [3:0]   a_done, a_grant, b_done, b_grant;
    logic [63:0]  a_rdata, a_swdata, b_rdata, b_swdata;
    logic         a_err, b_err;
    logic [1:0]   a_sreq, b_sreq;
    logic [23:0]  a_saddr, b_saddr;
    int n_cmp = 0;
    int n_bad = 0;

    sdram_rr_scheduler #(.URGENT_CYC(64), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_done(a_done), .o_rdata(a_rdata), .o_grant(a_grant),
        .o_err(a_err), .i_err_clr(i_err_clr), .sdram_req(a_sreq), .sdram_addr(a_saddr),
        .sdram_wdata(a_swdata), .sdram_rdata(sdram_rdata), .sdram_done(sdram_done)
    );

    sdram_rr_scheduler #(.URGENT_CYC(4), .TIMEOUT_CYC(16)) dut_b (
        .clk(clk), .rst(rst), .en(en), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_done(b_done), .o_rdata(b_rdata), .o_grant(b_grant),
        .o_err(b_err), .i_err_clr(i_err_clr), .sdram_req(b_sreq), .sdram_addr(b_saddr),
        .sdram_wdata(b_swdata), .sdram_rdata(sdram_rdata), .sdram_done(sdram_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b1; i_err_clr = 1'b0; i_req = 4'd0; i_we = 4'd0;
        i_addr = '0; i_wdata = '0; sdram_rdata = 64'd0; sdram_done = 2'd0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; i_err_clr = 1'b0; i_req = 4'd0; i_we = 4'd0;
        i_addr = '0; i_wdata = '0; sdram_rdata = 64'd0; sdram_done = 2'd0;
        tick(2);
        n_cmp++;
        if ({a_sreq, a_done, a_grant, a_err} !== 11'd0) begin
            n_bad++; $display("FAIL reset_ctrl got=%b exp=0", {a_sreq, a_done, a_grant, a_err});
        end
        n_cmp++;
        if (a_rdata !== 64'd0) begin
            n_bad++; $display("FAIL reset_rdata got=%h exp=0", a_rdata);
        end
        n_cmp++;
        if ({a_saddr, a_swdata} !== 88'd0) begin
            n_bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", a_saddr, a_swdata);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single_read;
        do_reset();
        i_addr[71:48] = 24'h012345;
        i_req = 4'b0100;
        tick(1);
        n_cmp++;
        if (a_sreq !== 2'b01) begin
            n_bad++; $display("FAIL rd_sreq got=%b exp=01", a_sreq);
        end
        n_cmp++;
        if (a_saddr !== 24'h012345) begin
            n_bad++; $display("FAIL rd_addr got=%h exp=012345", a_saddr);
        end
        n_cmp++;
        if (a_grant !== 4'b0100) begin
            n_bad++; $display("FAIL rd_grant got=%b exp=0100", a_grant);
        end
        tick(4);
        sdram_done = 2'b01;
        sdram_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick(1);
        sdram_done = 2'b00;
        i_req = 4'd0;
        n_cmp++;
        if (a_done !== 4'b0100) begin
            n_bad++; $display("FAIL rd_done got=%b exp=0100", a_done);
        end
        n_cmp++;
        if (a_rdata !== 64'hAAAA_BBBB_CCCC_DDDD) begin
            n_bad++; $display("FAIL rd_rdata got=%h exp=aaaabbbbccccdddd", a_rdata);
        end
        tick(1);
        n_cmp++;
        if ({a_done, a_grant} !== 8'd0) begin
            n_bad++; $display("FAIL rd_done_clear got=%b exp=0", {a_done, a_grant});
        end
    endtask

    task automatic test_rotation;
        logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0]  exp_r [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        logic [23:0] addr_tab [4] = '{24'h090000, 24'h1A0001, 24'h2B0002, 24'h3C0003};
        logic [63:0] wd_tab [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        logic [3:0]  prev = 4'd0;
        do_reset();
        i_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        i_wdata = {wd_tab[3], wd_tab[2], wd_tab[1], wd_tab[0]};
        i_we = 4'b1010;
        i_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            int w = 0;
            while (a_sreq == 2'b00 && w < 10) begin
                tick(1);
                w++;
            end
            n_cmp++;
            if (w >= 10) begin
                n_bad++; $display("FAIL rot_wait t=%0d got=timeout exp=grant", t);
            end
            n_cmp++;
            if (a_grant !== exp_g[t]) begin
                n_bad++; $display("FAIL rot_grant t=%0d got=%b exp=%b", t, a_grant, exp_g[t]);
            end
            n_cmp++;
            if (a_sreq !== exp_r[t]) begin
                n_bad++; $display("FAIL rot_dir t=%0d got=%b exp=%b", t, a_sreq, exp_r[t]);
            end
            n_cmp++;
            if (a_saddr !== addr_tab[t % 4]) begin
                n_bad++; $display("FAIL rot_addr t=%0d got=%h exp=%h", t, a_saddr, addr_tab[t % 4]);
            end
            if (exp_r[t] == 2'b10) begin
                n_cmp++;
                if (a_swdata !== wd_tab[t % 4]) begin
                    n_bad++; $display("FAIL rot_wdata t=%0d got=%h exp=%h", t, a_swdata, wd_tab[t % 4]);
                end
            end
            n_cmp++;
            if (a_grant === prev) begin
                n_bad++; $display("FAIL rot_repeat t=%0d got=%b exp=not %b", t, a_grant, prev);
            end
            prev = a_grant;
            tick(2);
            sdram_done = exp_r[t];
            tick(1);
            sdram_done = 2'b00;
            n_cmp++;
            if (a_done !== exp_g[t]) begin
                n_bad++; $display("FAIL rot_done t=%0d got=%b exp=%b", t, a_done, exp_g[t]);
            end
        end
        i_req = 4'd0;
        tick(3);
    endtask

    task automatic test_urgent;
        do_reset();
        i_req = 4'b1110;
        tick(1);
        n_cmp++;
        if ({a_grant, b_grant} !== 8'b0010_0010) begin
            n_bad++; $display("FAIL urg_first got=%b/%b exp=0010/0010", a_grant, b_grant);
        end
        i_req = 4'b1111;
        tick(2);
        sdram_done = 2'b01;
        tick(1);
        sdram_done = 2'b00;
        n_cmp++;
        if (b_done !== 4'b0010) begin
            n_bad++; $display("FAIL urg_done got=%b exp=0010", b_done);
        end
        tick(2);
        n_cmp++;
        if (b_grant !== 4'b0001) begin
            n_bad++; $display("FAIL urg_override got=%b exp=0001", b_grant);
        end
        n_cmp++;
        if (a_grant !== 4'b0100) begin
            n_bad++; $display("FAIL urg_rr_order got=%b exp=0100", a_grant);
        end
        i_req = 4'd0;
    endtask

    task automatic test_timeout;
        do_reset();
        i_req = 4'b0001;
        sdram_rdata = 64'h5555_5555_5555_5555;
        tick(1);
        n_cmp++;
        if (a_sreq !== 2'b01) begin
            n_bad++; $display("FAIL to_start got=%b exp=01", a_sreq);
        end
        tick(16);
        n_cmp++;
        if ({a_sreq, a_done} !== 6'b01_0000) begin
            n_bad++; $display("FAIL to_hold got=%b exp=010000", {a_sreq, a_done});
        end
        tick(1);
        i_req = 4'd0;
        n_cmp++;
        if ({a_sreq, a_done, a_err} !== 7'b00_0001_1) begin
            n_bad++; $display("FAIL to_abort got=%b exp=0000011", {a_sreq, a_done, a_err});
        end
        n_cmp++;
        if (a_rdata !== 64'd0) begin
            n_bad++; $display("FAIL to_rdata got=%h exp=0", a_rdata);
        end
        tick(2);
        n_cmp++;
        if ({a_err, a_done} !== 5'b1_0000) begin
            n_bad++; $display("FAIL to_sticky got=%b exp=10000", {a_err, a_done});
        end
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        n_cmp++;
        if (a_err !== 1'b0) begin
            n_bad++; $display("FAIL to_clear got=%b exp=0", a_err);
        end
        i_req = 4'b0001;
        i_err_clr = 1'b1;
        tick(18);
        i_req = 4'd0;
        n_cmp++;
        if ({a_done, a_err} !== 5'b0001_1) begin
            n_bad++; $display("FAIL to_set_wins got=%b exp=00011", {a_done, a_err});
        end
        tick(1);
        n_cmp++;
        if (a_err !== 1'b0) begin
            n_bad++; $display("FAIL to_clear_held got=%b exp=0", a_err);
        end
        i_err_clr = 1'b0;
    endtask

    task automatic test_enable_reset;
        do_reset();
        en = 1'b0;
        i_req = 4'b0010;
        tick(4);
        n_cmp++;
        if ({a_grant, a_sreq} !== 6'd0) begin
            n_bad++; $display("FAIL en_block got=%b exp=0", {a_grant, a_sreq});
        end
        en = 1'b1;
        tick(1);
        n_cmp++;
        if (a_grant !== 4'b0010) begin
            n_bad++; $display("FAIL en_grant got=%b exp=0010", a_grant);
        end
        en = 1'b0;
        tick(2);
        sdram_done = 2'b01;
        tick(1);
        sdram_done = 2'b00;
        i_req = 4'd0;
        n_cmp++;
        if (a_done !== 4'b0010) begin
            n_bad++; $display("FAIL en_drop_done got=%b exp=0010", a_done);
        end
        tick(2);
        en = 1'b1;
        i_req = 4'b0001;
        tick(1);
        n_cmp++;
        if (a_sreq !== 2'b01) begin
            n_bad++; $display("FAIL rst_pre got=%b exp=01", a_sreq);
        end
        tick(1);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_sreq, a_grant} !== 6'd0) begin
            n_bad++; $display("FAIL rst_async got=%b exp=0", {a_sreq, a_grant});
        end
        i_req = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if (a_done !== 4'd0) begin
            n_bad++; $display("FAIL rst_no_done got=%b exp=0", a_done);
        end
    endtask

    task automatic test_stale;
        do_reset();
        i_req = 4'b0010;
        tick(1);
        n_cmp++;
        if (a_grant !== 4'b0010) begin
            n_bad++; $display("FAIL stale_first got=%b exp=0010", a_grant);
        end
        tick(2);
        sdram_done = 2'b01;
        tick(1);
        sdram_done = 2'b00;
        n_cmp++;
        if (a_done !== 4'b0010) begin
            n_bad++; $display("FAIL stale_done got=%b exp=0010", a_done);
        end
        tick(2);
        n_cmp++;
        if ({a_grant, a_sreq} !== 6'd0) begin
            n_bad++; $display("FAIL stale_regrant got=%b exp=0", {a_grant, a_sreq});
        end
        i_req = 4'd0;
        tick(2);
        n_cmp++;
        if ({a_grant, a_sreq} !== 6'd0) begin
            n_bad++; $display("FAIL stale_idle got=%b exp=0", {a_grant, a_sreq});
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rotation();
        test_urgent();
        test_timeout();
        test_enable_reset();
        test_stale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_rr_scheduler.md
Name: sdram_rr_scheduler

Overview:
- Four-port round-robin scheduler in front of the 4-word-burst SDRAM base controller. It replaces fixed-order polling of requesters.
- Each port can issue a read or a write burst. Port 0 is the display read path and gets an anti-starvation urgent override.
- A watchdog aborts hung transactions.
- Sits between the TFT adapter, draw and shift engines and the SDRAM base controller's iReq/oDone interface.

Parameters:
- URGENT_CYC, 64: cycles port 0 may wait with req high before it is forced to win the next arbitration.
- TIMEOUT_CYC, 1023: maximum cycles in ISSUE waiting for the controller's done; exceeding it aborts the transaction.

Ports:
- clk  in  1  system clock (SDRAM clock domain)
- rst  in  1  asynchronous reset, active-high
- en  in  1  allow new grants; an in-flight transaction always completes
- i_req  in  4  per-port request, level, held until that port's done
- i_we  in  4  per-port direction: 1 = write, 0 = read
- i_addr  in  96  per-port address, port n at [24n+23:24n]: bank(2)+row(13)+col(9)
- i_wdata  in  256  per-port 4-word write data, port n at [64n+63:64n], word1 in the LSBs
- o_done  out  4  one-cycle completion pulse, one bit per port
- o_rdata  out  64  read burst data; valid in the cycle the reading port's o_done is high
- o_grant  out  4  one-hot owner during ISSUE/DONE, 0 otherwise
- o_err  out  1  sticky timeout flag
- i_err_clr  in  1  clears o_err
- sdram_req  out  2  to the controller: [1] = write, [0] = read; at most one bit set
- sdram_addr  out  24  latched address
- sdram_wdata  out  64  latched write data
- sdram_rdata  in  64  controller read data
- sdram_done  in  2  controller done: [1] = write done, [0] = read done

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the rr pointer to 3, so port 0 is first in search order.
  - sdram_req, o_done, o_grant, o_rdata and o_err all go to 0. sdram_addr and sdram_wdata go to 0.
  - Wait and timeout counters go to 0.
  - Reset mid-transaction drops sdram_req immediately. No done pulse is issued.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - Candidate set = i_req with the mask bit cleared.
  - If en=1 and the set is non-empty, select a winner:
    - port 0, if urgent is set and req0 is in the set;
    - otherwise the first set bit searching ptr+1, ptr+2, ... modulo 4.
  - Register the grant: o_grant=one-hot, sdram_addr/wdata latched from the winner, sdram_req = we ? 2'b10 : 2'b01. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - sdram_req, addr and wdata are held constant.
  - The timeout counter increments each cycle.
  - On the done bit matching direction, go to DONE: sdram_req=0; o_done[winner]=1; o_rdata=sdram_rdata if read (held otherwise); ptr=winner.
  - A non-matching done bit is ignored.
  - When the counter reaches TIMEOUT_CYC without done, go to DONE with o_done pulsed, o_err=1 and o_rdata unchanged.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - o_done returns to 0 and o_grant to 0.
  - Mask = the winner's bit for exactly that next IDLE cycle. This lets the requester drop req one cycle late without a duplicate grant.
- Latency: req seen in IDLE at cycle 0 → sdram_req high at cycle 1 → sdram_done at cycle k → o_done at cycle k+1 → IDLE at cycle k+2 → the next grant can be registered at k+3.
- Urgent wait counter:
  - 7 bits, saturating.
  - Increments each cycle req0=1 and port 0 is not the current owner.
  - Clears when port 0 is granted or req0=0.
  - urgent = counter ≥ URGENT_CYC.
- The rr pointer updates only on normal or timeout completion.
- en=0 in IDLE: no grant; counters keep running. en falling during ISSUE: the transaction completes normally.
- o_err: i_err_clr clears it. If a timeout sets it in the same cycle as a clear, set wins.
- Simultaneous requests from all ports with no urgent condition: grants rotate 0,1,2,3,0...

Test Plan:
- Single read on port 2, addr 0x012345: sdram_req=01 and sdram_addr=0x012345 the cycle after req. sdram_done=01 at 5 cycles with rdata=0xAAAA_BBBB_CCCC_DDDD gives o_done=0100 for one cycle and o_rdata equal to that value.
- All four i_req held high, i_we=1010, with the controller returning done after 3 cycles: grant order 0,1,2,3,0. sdram_req matches each port's direction (01, 10, 01, 10), and no port is granted twice in a row.
- Ports 1–3 kept continuously busy and req0 held high with URGENT_CYC=4: port 0 is granted at the first IDLE after its counter reaches 4, ahead of rr order.
- Controller never returns done, TIMEOUT_CYC=16: at cycle 17 of ISSUE sdram_req goes to 0, o_done pulses for that port and o_err=1. Pulsing i_err_clr gives o_err=0.
- en=0 with req on port 1: no grant. Dropping en mid-ISSUE lets the burst complete with o_done. rst asserted mid-ISSUE: sdram_req=0 immediately and no o_done.
- Requester holds req1 one cycle past o_done: no second grant to port 1 from that stale cycle.
